puf_key_packer: RTL

//  Downstream stage of ro_pair_puf. Captures one result vector (NROP per-pair ACC-bit win counts)
//  via the res_valid/res_ready handshake. Converts each count to a key bit plus a stability flag,

---
 rtl/puf_pkg.sv | 39 +++
 rtl/puf_bit_classify.sv | 26 ++
 rtl/puf_key_packer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/puf_pkg.sv
// Shared definitions for the ring-oscillator PUF datapath: default sizes,
// the packer state encoding and small helper functions.
package puf_pkg;

    // Ring-oscillator PUF defaults shared with ro_pair_puf.
    localparam int NROP_DEF   = 256;
    localparam int ACC_DEF    = 7;
    localparam int NDLY_DEF   = 8;
    localparam int NSTOP_DEF  = 16;

    // Key packer defaults.
    localparam int MARGIN_DEF = 8;
    localparam int WORD_DEF   = 8;

    // Widest vector the popcount helper accepts; callers zero-extend.
    localparam int POP_MAX    = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        EMIT = 2'd2
    } state_t;

    // Midpoint of an acc-bit unsigned count: a pair that wins exactly half
    // its races sits here.
    function automatic int mid_of(input int acc);
        return 1 << (acc - 1);
    endfunction

    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/puf_bit_classify.sv
// Turns one pair's win count into a key bit and a stability flag.
// Key bit is set when the count reaches the midpoint; the bit is stable when
// the count lies at least MARGIN away from the midpoint (MARGIN <= MID).
module puf_bit_classify
    import puf_pkg::*;
#(
    parameter int ACC    = ACC_DEF,
    parameter int MARGIN = MARGIN_DEF
) (
    input  logic [ACC-1:0] i_count,
    output logic           o_key_bit,
    output logic           o_stable
);

    // One extra bit keeps count + MARGIN and MID + MARGIN from wrapping.
    localparam logic [ACC:0] MID_X    = (ACC+1)'(mid_of(ACC));
    localparam logic [ACC:0] MARGIN_X = (ACC+1)'(MARGIN);

    logic [ACC:0] w_count_x;

    assign w_count_x = {1'b0, i_count};
    assign o_key_bit = (w_count_x >= MID_X);
    assign o_stable  = (w_count_x >= MID_X + MARGIN_X) ||
                       (w_count_x + MARGIN_X <= MID_X);

endmodule

// File: rtl/puf_key_packer.sv
// Captures one PUF result vector, classifies every pair and streams the key
// bits with their stability mask WORD bits per beat. Also reports how many
// pairs of the last fully streamed vector were unstable.
module puf_key_packer
    import puf_pkg::*;
#(
    parameter int NROP   = NROP_DEF,
    parameter int ACC    = ACC_DEF,
    parameter int MARGIN = MARGIN_DEF,
    parameter int WORD   = WORD_DEF
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NROP*ACC-1:0]       co_v,
    input  logic                      res_valid,
    output logic                      res_ready,
    output logic [WORD-1:0]           key_data,
    output logic [WORD-1:0]           key_mask,
    output logic                      key_valid,
    input  logic                      key_ready,
    output logic                      key_last,
    output logic [$clog2(NROP+1)-1:0] unstable_cnt,
    output logic                      done
);

    localparam int NW     = NROP / WORD;
    localparam int WIDX_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int CNT_W  = $clog2(NROP + 1);
    localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(NW - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [WORD*ACC-1:0]   r_cap [NW];
    logic [WIDX_W-1:0]     r_widx;
    logic [WIDX_W-1:0]     w_word_idx;
    logic [CNT_W-1:0]      r_running;
    logic [CNT_W-1:0]      r_unstable;
    logic [CNT_W-1:0]      w_beat_unstable;
    logic                  r_res_ready;
    logic                  r_key_valid;
    logic                  r_key_last;
    logic                  r_done;
    logic [WORD-1:0]       r_key_data;
    logic [WORD-1:0]       r_key_mask;
    logic [WORD-1:0]       w_bits;
    logic [WORD-1:0]       w_stable;
    logic [WORD-1:0]       w_unstable_bits;
    logic [WORD*ACC-1:0]   w_word;
    logic                  w_xfer;
    logic                  w_accept;
    logic                  w_load;

    assign w_xfer   = (r_state == IDLE) && res_valid && r_res_ready;
    assign w_accept = (r_state == EMIT) && r_key_valid && key_ready;

    // CAPT classifies the current word; in EMIT the word being loaded is the
    // one after the beat that is being accepted.
    assign w_word_idx = (r_state == EMIT) ? r_widx + 1'b1 : r_widx;
    assign w_word     = r_cap[w_word_idx];

    for (genvar j = 0; j < WORD; j++) begin : g_cls
        puf_bit_classify #(
            .ACC    (ACC),
            .MARGIN (MARGIN)
        ) u_cls (
            .i_count   (w_word[j*ACC +: ACC]),
            .o_key_bit (w_bits[j]),
            .o_stable  (w_stable[j])
        );
    end

    assign w_unstable_bits = ~r_key_mask;
    assign w_beat_unstable = CNT_W'(popcount(POP_MAX'(w_unstable_bits)));

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state and word-load decision.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a value
        // unassigned, which would infer a latch.
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: if (w_xfer) w_state_next = CAPT;
            CAPT: begin
                w_load       = 1'b1;
                w_state_next = EMIT;
            end
            EMIT: begin
                if (w_accept) begin
                    if (r_key_last) w_state_next = IDLE;
                    else            w_load       = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Capture buffer, written only on an IDLE handshake.
    always_ff @(posedge clk) begin
        // NOTE: the capture buffer is pure data and is always written before
        // it is read, so it carries no reset.
        if (w_xfer) begin
            for (int i = 0; i < NW; i++) begin
                r_cap[i] <= co_v[i*WORD*ACC +: WORD*ACC];
            end
        end
    end

    // Output beat registers, word index, unstable accounting and handshakes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_res_ready <= 1'b0;
            r_key_valid <= 1'b0;
            r_key_last  <= 1'b0;
            r_key_data  <= '0;
            r_key_mask  <= '0;
            r_done      <= 1'b0;
            r_widx      <= '0;
            r_running   <= '0;
            r_unstable  <= '0;
        end else begin
            r_done      <= 1'b0;
            // Ready comes up one cycle after re-entering IDLE, so it stays
            // low during the done pulse.
            r_res_ready <= (r_state == IDLE) && !w_xfer;
            if (w_xfer) begin
                r_widx    <= '0;
                r_running <= '0;
            end
            if (w_load) begin
                r_key_data  <= w_bits;
                r_key_mask  <= w_stable;
                r_key_last  <= (w_word_idx == LAST_IDX);
                r_key_valid <= 1'b1;
            end
            if (w_accept) begin
                if (r_key_last) begin
                    r_key_valid <= 1'b0;
                    r_key_last  <= 1'b0;
                    r_unstable  <= r_running + w_beat_unstable;
                    r_done      <= 1'b1;
                end else begin
                    r_running <= r_running + w_beat_unstable;
                    r_widx    <= r_widx + 1'b1;
                end
            end
        end
    end

    assign res_ready    = r_res_ready;
    assign key_data     = r_key_data;
    assign key_mask     = r_key_mask;
    assign key_valid    = r_key_valid;
    assign key_last     = r_key_last;
    assign unstable_cnt = r_unstable;
    assign done         = r_done;

endmodule
